// File: rtl/multicycle_control.sv
`default_nettype none
//============================================================================
// Module      : multicycle_control
// Description : Sequencing control unit for a multicycle RV32 datapath.
//               Walks each instruction through fetch/decode/execute/memory/
//               writeback, driving mux selects, write strobes and the 4-bit
//               ALU operation code. Optional macro MEM_WAIT_EN adds
//               MEM_READY wait states in FETCH, MEMREAD and MEMWRITE.
// Revision    : 1.0 - initial release
//============================================================================
module multicycle_control (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] INSTR,
    input  logic        ZERO,
    input  logic        MEM_READY,
    output logic        PC_WRITE,
    output logic        ADR_SRC,
    output logic        MEM_WRITE,
    output logic        IR_WRITE,
    output logic        REG_WRITE,
    output logic [1:0]  RESULT_SRC,
    output logic [1:0]  ALU_SRC_A,
    output logic [1:0]  ALU_SRC_B,
    output logic [3:0]  ALU_OPERATION,
    output logic        ILLEGAL
);

    localparam logic [6:0] c_OPC_LW   = 7'b0000011;
    localparam logic [6:0] c_OPC_SW   = 7'b0100011;
    localparam logic [6:0] c_OPC_R    = 7'b0110011;
    localparam logic [6:0] c_OPC_I    = 7'b0010011;
    localparam logic [6:0] c_OPC_BEQ  = 7'b1100011;

    localparam logic [3:0] c_ALU_AND  = 4'b0000;
    localparam logic [3:0] c_ALU_OR   = 4'b0001;
    localparam logic [3:0] c_ALU_ADD  = 4'b0010;
    localparam logic [3:0] c_ALU_SUB  = 4'b0110;
    localparam logic [3:0] c_ALU_NONE = 4'b1111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_ILLEGAL  = 4'd10
    } state_t;

    // pc_write is the unconditional load (FETCH); pc_beq asks for a
    // ZERO-qualified load in the branch cycle.
    typedef struct packed {
        logic       pc_write;
        logic       pc_beq;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       illegal;
    } ctrl_t;

    // Moore output table: control word shown while in state s.
    function automatic ctrl_t f_ctrl(input state_t s, input logic [3:0] r_op,
                                     input logic [3:0] i_op);
        ctrl_t c;
        c        = '0;
        c.alu_op = c_ALU_NONE;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_write   = 1'b1;
                c.alu_src_b  = 2'b10;
                c.alu_op     = c_ALU_ADD;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
                c.alu_op    = c_ALU_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = c_ALU_ADD;
            end
            S_MEMREAD:  c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = r_op;
            end
            S_EXECUTEI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = i_op;
            end
            S_ALUWB:    c.reg_write = 1'b1;
            S_BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = c_ALU_SUB;
                c.pc_beq    = 1'b1;
            end
            S_ILLEGAL:  c.illegal = 1'b1;
            default:    c.alu_op = c_ALU_NONE;
        endcase
        return c;
    endfunction

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [3:0] w_r_op;
    logic [3:0] w_i_op;
    logic       w_ready;
    state_t     r_state;
    state_t     w_next;
    ctrl_t      r_ctrl;
    ctrl_t      w_ctrl;
    ctrl_t      w_fetch_ctrl;

    assign w_opcode     = INSTR[6:0];
    assign w_funct3     = INSTR[14:12];
    assign w_funct7     = INSTR[31:25];
    assign w_fetch_ctrl = f_ctrl(S_FETCH, c_ALU_NONE, c_ALU_NONE);

`ifdef MEM_WAIT_EN
    assign w_ready = MEM_READY;
    logic w_unused_instr;
    assign w_unused_instr = ^{INSTR[24:15], INSTR[11:7]};
`else
    // Without wait states every state lasts exactly one cycle.
    assign w_ready = 1'b1;
    logic w_unused_instr;
    assign w_unused_instr = ^{INSTR[24:15], INSTR[11:7], MEM_READY};
`endif

    // ALU op lookup for R-type and I-type; NONE marks an unsupported form.
    always_comb begin
        w_r_op = c_ALU_NONE;
        w_i_op = c_ALU_NONE;
        case ({w_funct7, w_funct3})
            {7'b0000000, 3'b000}: w_r_op = c_ALU_ADD;
            {7'b0100000, 3'b000}: w_r_op = c_ALU_SUB;
            {7'b0000000, 3'b111}: w_r_op = c_ALU_AND;
            {7'b0000000, 3'b110}: w_r_op = c_ALU_OR;
            default:              w_r_op = c_ALU_NONE;
        endcase
        case (w_funct3)
            3'b000:  w_i_op = c_ALU_ADD;
            3'b111:  w_i_op = c_ALU_AND;
            3'b110:  w_i_op = c_ALU_OR;
            default: w_i_op = c_ALU_NONE;
        endcase
    end

    // Next-state selection; memory-facing states hold until w_ready.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (w_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    c_OPC_LW, c_OPC_SW: w_next = S_MEMADR;
                    c_OPC_R:   w_next = (w_r_op != c_ALU_NONE) ? S_EXECUTER : S_ILLEGAL;
                    c_OPC_I:   w_next = (w_i_op != c_ALU_NONE) ? S_EXECUTEI : S_ILLEGAL;
                    c_OPC_BEQ: w_next = (w_funct3 == 3'b000) ? S_BEQ : S_ILLEGAL;
                    default:   w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   w_next = (w_opcode == c_OPC_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (w_ready) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (w_ready) w_next = S_FETCH;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_ILLEGAL:  w_next = S_ILLEGAL;
            default:    w_next = S_FETCH;
        endcase
    end

    // State register plus the control word registered for the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_FETCH;
            r_ctrl  <= w_fetch_ctrl;
        end else begin
            r_state <= w_next;
            r_ctrl  <= f_ctrl(w_next, w_r_op, w_i_op);
        end
    end

    // While RST is high the outputs show FETCH values with every strobe
    // suppressed, so an aborted instruction never writes anything.
    assign w_ctrl        = RST ? w_fetch_ctrl : r_ctrl;
    assign PC_WRITE      = ~RST & ((r_ctrl.pc_write & w_ready) | (r_ctrl.pc_beq & ZERO));
    assign IR_WRITE      = ~RST & r_ctrl.ir_write & w_ready;
    assign MEM_WRITE     = ~RST & r_ctrl.mem_write;
    assign REG_WRITE     = ~RST & r_ctrl.reg_write;
    assign ADR_SRC       = w_ctrl.adr_src;
    assign RESULT_SRC    = w_ctrl.result_src;
    assign ALU_SRC_A     = w_ctrl.alu_src_a;
    assign ALU_SRC_B     = w_ctrl.alu_src_b;
    assign ALU_OPERATION = w_ctrl.alu_op;
    assign ILLEGAL       = w_ctrl.illegal;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
//============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. Directed
//               instructions; expected outputs come from an instruction-level
//               schedule model plus literal spot checks.
// Revision    : 1.0 - initial release
//============================================================================
module tb_multicycle_control;

    logic        clk;
    logic        rst;
    logic        zero;
    logic        mem_ready;
    logic [31:0] instr;
    logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0]  result_src, alu_src_a, alu_src_b;
    logic [3:0]  alu_operation;

    multicycle_control dut (
        .CLK(clk), .RST(rst), .INSTR(instr), .ZERO(zero), .MEM_READY(mem_ready),
        .PC_WRITE(pc_write), .ADR_SRC(adr_src), .MEM_WRITE(mem_write),
        .IR_WRITE(ir_write), .REG_WRITE(reg_write), .RESULT_SRC(result_src),
        .ALU_SRC_A(alu_src_a), .ALU_SRC_B(alu_src_b),
        .ALU_OPERATION(alu_operation), .ILLEGAL(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write, adr_src, mem_write, ir_write, reg_write;
        logic [1:0] result_src, alu_a, alu_b;
        logic [3:0] alu_op;
        logic       illegal;
    } obs_t;

    typedef enum {P_RESET, P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB,
                  P_MEMWRITE, P_EXEC_R, P_EXEC_I, P_ALUWB, P_BEQ, P_ILLEGAL} phase_t;
    typedef enum {M_LW, M_SW, M_ADD, M_SUB, M_AND, M_OR, M_ADDI, M_ANDI, M_ORI,
                  M_BEQ, M_ILL, M_NONE} mn_t;

    obs_t   dut_obs;
    obs_t   exp_q[$];
    string  name_q[$];
    obs_t   snap[$];
    phase_t plan_q[$];
    obs_t   cmp_e;
    string  cmp_n;
    int     n_vec  = 0;
    int     n_miss = 0;

    always_comb dut_obs = {pc_write, adr_src, mem_write, ir_write, reg_write,
                           result_src, alu_src_a, alu_src_b, alu_operation, illegal};

    // Instruction mnemonic straight from the supported-instruction list.
    function automatic mn_t mnem(input logic [31:0] ins);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        case (opc)
            7'h03: return M_LW;
            7'h23: return M_SW;
            7'h33: begin
                if (f7 == 7'h00 && f3 == 3'd0) return M_ADD;
                if (f7 == 7'h20 && f3 == 3'd0) return M_SUB;
                if (f7 == 7'h00 && f3 == 3'd7) return M_AND;
                if (f7 == 7'h00 && f3 == 3'd6) return M_OR;
                return M_ILL;
            end
            7'h13: begin
                if (f3 == 3'd0) return M_ADDI;
                if (f3 == 3'd7) return M_ANDI;
                if (f3 == 3'd6) return M_ORI;
                return M_ILL;
            end
            7'h63: return (f3 == 3'd0) ? M_BEQ : M_ILL;
            default: return M_ILL;
        endcase
    endfunction

    function automatic logic [3:0] op_of(input mn_t m);
        case (m)
            M_ADD, M_ADDI: return 4'b0010;
            M_SUB:         return 4'b0110;
            M_AND, M_ANDI: return 4'b0000;
            M_OR,  M_ORI:  return 4'b0001;
            default:       return 4'b1111;
        endcase
    endfunction

    // Expected outputs for one phase of an instruction.
    function automatic obs_t spec_row(input phase_t ph, input mn_t m, input logic z,
                                      input logic rdy);
        obs_t o;
        logic go;
        o        = '0;
        o.alu_op = 4'b1111;
`ifdef MEM_WAIT_EN
        go = rdy;
`else
        go = rdy | 1'b1;
`endif
        case (ph)
            P_RESET:    begin o.alu_b = 2'b10; o.alu_op = 4'b0010; o.result_src = 2'b10; end
            P_FETCH:    begin o.alu_b = 2'b10; o.alu_op = 4'b0010; o.result_src = 2'b10;
                              o.ir_write = go; o.pc_write = go; end
            P_DECODE:   begin o.alu_a = 2'b01; o.alu_b = 2'b01; o.alu_op = 4'b0010; end
            P_MEMADR:   begin o.alu_a = 2'b10; o.alu_b = 2'b01; o.alu_op = 4'b0010; end
            P_MEMREAD:  o.adr_src = 1'b1;
            P_MEMWB:    begin o.result_src = 2'b01; o.reg_write = 1'b1; end
            P_MEMWRITE: begin o.adr_src = 1'b1; o.mem_write = 1'b1; end
            P_EXEC_R:   begin o.alu_a = 2'b10; o.alu_b = 2'b00; o.alu_op = op_of(m); end
            P_EXEC_I:   begin o.alu_a = 2'b10; o.alu_b = 2'b01; o.alu_op = op_of(m); end
            P_ALUWB:    o.reg_write = 1'b1;
            P_BEQ:      begin o.alu_a = 2'b10; o.alu_op = 4'b0110; o.pc_write = z; end
            P_ILLEGAL:  o.illegal = 1'b1;
            default:    o = '0;
        endcase
        return o;
    endfunction

    // Cycle-by-cycle phase list for a whole instruction.
    function automatic void build_plan(input mn_t m);
        plan_q.delete();
        plan_q.push_back(P_FETCH);
        plan_q.push_back(P_DECODE);
        case (m)
            M_LW:  begin plan_q.push_back(P_MEMADR); plan_q.push_back(P_MEMREAD);
                         plan_q.push_back(P_MEMWB); end
            M_SW:  begin plan_q.push_back(P_MEMADR); plan_q.push_back(P_MEMWRITE); end
            M_ADD, M_SUB, M_AND, M_OR:
                   begin plan_q.push_back(P_EXEC_R); plan_q.push_back(P_ALUWB); end
            M_ADDI, M_ANDI, M_ORI:
                   begin plan_q.push_back(P_EXEC_I); plan_q.push_back(P_ALUWB); end
            M_BEQ: plan_q.push_back(P_BEQ);
            default: for (int k = 0; k < 20; k++) plan_q.push_back(P_ILLEGAL);
        endcase
    endfunction

    // Compare process: one expectation per cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            cmp_n = name_q.pop_front();
            n_vec++;
            if (dut_obs !== cmp_e) begin
                n_miss++;
                $display("FAIL %s: got %h want %h", cmp_n, dut_obs, cmp_e);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic one_cycle(input phase_t ph, input mn_t m, input logic [31:0] ins,
                             input logic rst_v, input logic z, input logic rdy);
        @(posedge clk);
        #1;
        rst       = rst_v;
        zero      = z;
        mem_ready = rdy;
        instr     = ins;
        exp_q.push_back(rst_v ? spec_row(P_RESET, m, z, rdy) : spec_row(ph, m, z, rdy));
        name_q.push_back($sformatf("%s/%s", m.name(), rst_v ? "RESET" : ph.name()));
        #1;
        snap.push_back(dut_obs);
    endtask

    task automatic reset_cycles(input int n);
        snap.delete();
        for (int k = 0; k < n; k++) one_cycle(P_RESET, M_NONE, instr, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic run(input logic [31:0] ins, input logic z, input phase_t stall_ph,
                       input int nstall);
        mn_t m;
        m = mnem(ins);
        build_plan(m);
        snap.delete();
        foreach (plan_q[i]) begin
            if (plan_q[i] == stall_ph)
                for (int k = 0; k < nstall; k++) one_cycle(plan_q[i], m, ins, 1'b0, z, 1'b0);
            one_cycle(plan_q[i], m, ins, 1'b0, z, 1'b1);
        end
    endtask

    int n_mw;

    initial begin
        rst = 1'b1; zero = 1'b0; mem_ready = 1'b1; instr = 32'h0;

        reset_cycles(2);
        lit("rst_strobes", {28'h0, snap[1].pc_write, snap[1].ir_write,
                            snap[1].mem_write, snap[1].reg_write}, 32'h0);
        lit("rst_illegal", {31'h0, snap[1].illegal}, 32'h0);

        run(32'h002081B3, 1'b0, P_RESET, 0);               // add
        lit("first_fetch_irw", {31'h0, snap[0].ir_write}, 32'h1);
        lit("first_fetch_pcw", {31'h0, snap[0].pc_write}, 32'h1);
        lit("first_fetch_op",  {28'h0, snap[0].alu_op}, 32'h2);
        lit("add_exec_op",     {28'h0, snap[2].alu_op}, 32'h2);
        lit("add_wb_regw",     {31'h0, snap[3].reg_write}, 32'h1);

        run(32'h402081B3, 1'b0, P_RESET, 0);               // sub
        lit("sub_exec_op", {28'h0, snap[2].alu_op}, 32'h6);
        run(32'h0020F1B3, 1'b0, P_RESET, 0);               // and
        lit("and_exec_op", {28'h0, snap[2].alu_op}, 32'h0);
        run(32'h0020E1B3, 1'b0, P_RESET, 0);               // or
        lit("or_exec_op",  {28'h0, snap[2].alu_op}, 32'h1);
        run(32'h00508093, 1'b0, P_RESET, 0);               // addi
        run(32'h0010E093, 1'b0, P_RESET, 0);               // ori

        run(32'h00208463, 1'b1, P_RESET, 0);               // beq taken
        lit("beq_z1_pcw", {31'h0, snap[2].pc_write}, 32'h1);
        lit("beq_z1_op",  {28'h0, snap[2].alu_op}, 32'h6);
        run(32'h00208463, 1'b0, P_RESET, 0);               // beq not taken
        lit("beq_z0_pcw", {31'h0, snap[2].pc_write}, 32'h0);

        run(32'h0040A183, 1'b0, P_RESET, 0);               // lw
        lit("lw_wb_rsrc", {30'h0, snap[4].result_src}, 32'h1);
        lit("lw_wb_regw", {31'h0, snap[4].reg_write}, 32'h1);
        run(32'h0030A223, 1'b0, P_RESET, 0);               // sw
        n_mw = 0;
        foreach (snap[i]) n_mw += int'(snap[i].mem_write);
        lit("sw_memwrite_count", n_mw, 32'd1);

        // Reset arriving in the MEMWRITE cycle must suppress the write.
        snap.delete();
        one_cycle(P_FETCH,  M_SW, 32'h0030A223, 1'b0, 1'b0, 1'b1);
        one_cycle(P_DECODE, M_SW, 32'h0030A223, 1'b0, 1'b0, 1'b1);
        one_cycle(P_MEMADR, M_SW, 32'h0030A223, 1'b0, 1'b0, 1'b1);
        one_cycle(P_MEMWRITE, M_SW, 32'h0030A223, 1'b1, 1'b0, 1'b1);
        lit("sw_abort_memwrite", {31'h0, snap[3].mem_write}, 32'h0);
        one_cycle(P_RESET, M_NONE, 32'h0030A223, 1'b1, 1'b0, 1'b1);
        run(32'h0020F1B3, 1'b0, P_RESET, 0);               // and after abort

        run(32'h0020C1B3, 1'b0, P_RESET, 0);               // xor: unsupported
        lit("xor_illegal", {31'h0, snap[2].illegal}, 32'h1);
        reset_cycles(2);

        run(32'hFFFFFFFF, 1'b0, P_RESET, 0);
        lit("ill_cycle3", {31'h0, snap[2].illegal}, 32'h1);
        lit("ill_cycle22", {31'h0, snap[21].illegal}, 32'h1);
        reset_cycles(2);
        lit("ill_cleared", {31'h0, snap[0].illegal}, 32'h0);
        run(32'h002081B3, 1'b0, P_RESET, 0);               // recovery

`ifdef MEM_WAIT_EN
        run(32'h0040A183, 1'b0, P_MEMREAD, 3);
        lit("wait_lw_hold_adr", {31'h0, snap[5].adr_src}, 32'h1);
        lit("wait_lw_memwb",    {31'h0, snap[7].reg_write}, 32'h1);
        run(32'h0030A223, 1'b0, P_MEMWRITE, 2);
        n_mw = 0;
        foreach (snap[i]) n_mw += int'(snap[i].mem_write);
        lit("wait_sw_memwrite_count", n_mw, 32'd3);
        run(32'h002081B3, 1'b0, P_FETCH, 2);
        lit("wait_fetch_irw", {31'h0, snap[0].ir_write}, 32'h0);
`endif

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Sequencing control unit for the multicycle RV32 datapath. It walks each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath mux selects and write strobes. It is the unit that issues the 4-bit ALU_OPERATION code to the datapath ALU, using the encodings AND=0000, OR=0001, ADD=0010 and SUB=0110.

## Interface
- No parameters; all widths are fixed by the RV32 datapath.
- CLK  input  1  single clock; all state updates on rising edge
- RST  input  1  reset, synchronous, active-high
- INSTR  input  32  current instruction from the datapath instruction register; valid from DECODE onward
- ZERO  input  1  ALU zero flag, used in BEQ
- MEM_READY  input  1  memory completion; used only with MEM_WAIT_EN
- PC_WRITE  output  1  PC register load strobe
- ADR_SRC  output  1  memory address select: 0=PC, 1=ALUOut
- MEM_WRITE  output  1  data memory write strobe
- IR_WRITE  output  1  instruction/oldPC register load strobe
- REG_WRITE  output  1  register file write strobe
- RESULT_SRC  output  2  result mux: 00=ALUOut, 01=memory data, 10=ALU result
- ALU_SRC_A  output  2  ALU A operand: 00=PC, 01=oldPC, 10=rs1
- ALU_SRC_B  output  2  ALU B operand: 00=rs2, 01=immediate, 10=constant 4
- ALU_OPERATION  output  4  ALU op code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1111 none/illegal
- ILLEGAL  output  1  sticky flag for an unsupported instruction

## Operation
- Moore FSM with a 4-bit state register. Outputs are decoded from the state, except that PC_WRITE in BEQ is qualified by ZERO.
- Supported opcodes: 0000011 lw, 0100011 sw, 0110011 R-type, 0010011 I-type ALU, 1100011 beq.
- Any other opcode, or an unsupported funct3/funct7 combination, causes DECODE to go to ILLEGAL.
- States, outputs and transitions (signals not listed are 0 / 00; ALU_OPERATION is 1111 unless listed):
  - FETCH: ADR_SRC=0, IR_WRITE=1, A=00, B=10, ADD, RESULT_SRC=10, PC_WRITE=1. Next: DECODE.
  - DECODE: A=01, B=01, ADD (precomputes the branch target into ALUOut). Next by opcode: MEMADR (lw/sw), EXECUTER, EXECUTEI, BEQ, or ILLEGAL.
  - MEMADR: A=10, B=01, ADD. Next: MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD: ADR_SRC=1, RESULT_SRC=00. Next: MEMWB.
  - MEMWB: RESULT_SRC=01, REG_WRITE=1. Next: FETCH.
  - MEMWRITE: ADR_SRC=1, RESULT_SRC=00, MEM_WRITE=1. Next: FETCH.
  - EXECUTER: A=10, B=00. Op by funct3/funct7: 000/0000000→ADD, 000/0100000→SUB, 111/0000000→AND, 110/0000000→OR. Next: ALUWB.
  - EXECUTEI: A=10, B=01. Op by funct3: 000→ADD, 111→AND, 110→OR. Next: ALUWB.
  - ALUWB: RESULT_SRC=00, REG_WRITE=1. Next: FETCH.
  - BEQ: A=10, B=00, SUB, RESULT_SRC=00, PC_WRITE=ZERO. Requires funct3=000, otherwise DECODE goes to ILLEGAL. Next: FETCH.
  - ILLEGAL: ILLEGAL=1, all strobes 0, ALU_OPERATION=1111. Stays here until RST.
- Field slices: opcode=INSTR[6:0], funct3=INSTR[14:12], funct7=INSTR[31:25].

## Timing
- RST high at a rising edge puts the state in FETCH on that edge.
- While RST is high, PC_WRITE, IR_WRITE, MEM_WRITE and REG_WRITE are forced to 0 combinationally. All other outputs show FETCH values. ILLEGAL=0.
- After RST falls, the first FETCH cycle asserts its strobes normally.
- RST mid-instruction aborts that instruction. No write strobe reaches the datapath once RST is seen high.
- Cycle counts per instruction, with no wait states: lw 5, sw 4, R-type 4, I-type 4, beq 3.
- ZERO is sampled combinationally in the BEQ cycle only. ZERO in any other state has no effect.
- INSTR is ignored in FETCH; IR is being loaded in that cycle.

## Configuration
- MEM_WAIT_EN defined:
  - FETCH, MEMREAD and MEMWRITE hold their state while MEM_READY=0.
  - In FETCH, IR_WRITE and PC_WRITE are gated by MEM_READY.
  - MEM_WRITE and ADR_SRC stay asserted on every held cycle.
  - The state advances on the first edge where MEM_READY=1.
- MEM_WAIT_EN undefined: MEM_READY is ignored, and every state lasts exactly one cycle.

## Test plan
- Reset for 2 cycles, then release:
  - during reset, all strobes are 0 and ILLEGAL=0;
  - the first cycle after release shows IR_WRITE=1, PC_WRITE=1, ALU_OPERATION=0010.
- INSTR=0x002081B3 (add x3,x1,x2): sequence FETCH, DECODE, EXECUTER with ALU_OPERATION=0010, then ALUWB with REG_WRITE=1, then back in FETCH on cycle 5.
- INSTR=0x402081B3 (sub): EXECUTER shows ALU_OPERATION=0110. INSTR=0x0020F1B3 (and): shows 0000. INSTR=0x0020E1B3 (or): shows 0001.
- beq 0x00208463 run twice:
  - with ZERO=1, BEQ cycle shows PC_WRITE=1 and ALU_OPERATION=0110;
  - with ZERO=0, PC_WRITE=0;
  - both runs return to FETCH.
- lw 0x0040A183 takes 5 cycles, with MEMWB showing RESULT_SRC=01 and REG_WRITE=1. sw 0x0030A223 takes 4 cycles, with MEM_WRITE=1 exactly once.
- INSTR=0xFFFFFFFF: ILLEGAL=1 from cycle 3 onward and stays high for 20 cycles with no strobes; it clears after RST.
- With MEM_WAIT_EN and MEM_READY=0 for 3 cycles during lw MEMREAD: the state holds for 4 cycles, then MEMWB.
